// File: rtl/button_event_pkg.sv
// Shared types for the button event scheduler: event kinds, channel FSM
// states and the per-button pending slot.
package button_event_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      EVT_NONE    = 2'b00,
      EVT_PRESS   = 2'b01,
      EVT_RELEASE = 2'b10,
      EVT_REPEAT  = 2'b11
   } evt_kind_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_HELD,
      ST_REL
   } btn_state_t;

   typedef struct packed {
      logic      vld;
      evt_kind_t kind;
   } slot_t;

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, debounce/auto-repeat FSM on the shared tick,
// and a single-entry pending event slot drained by the arbiter.
module button_channel
   import button_event_pkg::*;
#(
   parameter int STABLE_TICKS  = 4,
   parameter int REPEAT_DELAY  = 200,
   parameter int REPEAT_PERIOD = 40
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  btn_raw,
   input  logic  tick,
   input  logic  drain,
   input  logic  repeat_en,
   output logic  level,
   output slot_t slot,
   output logic  drop
);

   localparam int CW = $clog2(STABLE_TICKS) + 1;
   localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

   logic [SYNC_STAGES-1:0] sync_pipe;
   logic                   s;
   btn_state_t             state;
   logic [CW-1:0]          cnt;
   logic [RW-1:0]          rpt;
   logic [RW-1:0]          rpt_inc;
   logic                   cnt_done;
   logic                   post;
   evt_kind_t              post_kind;

   assign s        = sync_pipe[SYNC_STAGES-1];
   assign rpt_inc  = rpt + RW'(1);
   assign cnt_done = (cnt == CW'(STABLE_TICKS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_pipe <= '0;
      else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], btn_raw};
   end

   always_comb begin
      post      = 1'b0;
      post_kind = EVT_NONE;
      if (tick) begin
         case (state)
            ST_ARM:  if (s && cnt_done) begin post = 1'b1; post_kind = EVT_PRESS; end
            ST_REL:  if (!s && cnt_done) begin post = 1'b1; post_kind = EVT_RELEASE; end
            ST_HELD: if (s && repeat_en && (rpt_inc == RW'(REPEAT_DELAY) ||
                         rpt_inc == RW'(REPEAT_DELAY + REPEAT_PERIOD))) begin
                        post = 1'b1; post_kind = EVT_REPEAT;
                     end
            default: ;
         endcase
      end
   end

   // rpt folds back to REPEAT_DELAY after each period so it never grows unbounded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         rpt   <= '0;
         level <= 1'b0;
      end else if (tick) begin
         case (state)
            ST_IDLE: if (s) begin state <= ST_ARM; cnt <= CW'(1); end
            ST_ARM: begin
               if (!s) begin state <= ST_IDLE; cnt <= '0; end
               else if (cnt_done) begin
                  state <= ST_HELD; level <= 1'b1; rpt <= '0; cnt <= '0;
               end else cnt <= cnt + CW'(1);
            end
            ST_HELD: begin
               if (!s) begin state <= ST_REL; cnt <= CW'(1); end
               else if (!repeat_en) rpt <= '0;
               else if (rpt_inc == RW'(REPEAT_DELAY + REPEAT_PERIOD)) rpt <= RW'(REPEAT_DELAY);
               else rpt <= rpt_inc;
            end
            ST_REL: begin
               if (s) begin state <= ST_HELD; cnt <= '0; end
               else if (cnt_done) begin
                  state <= ST_IDLE; level <= 1'b0; cnt <= '0;
               end else cnt <= cnt + CW'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign drop = post && slot.vld && !drain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     slot <= '{vld: 1'b0, kind: EVT_NONE};
      else if (post)  slot <= '{vld: 1'b1, kind: post_kind};
      else if (drain) slot <= '{vld: 1'b0, kind: EVT_NONE};
   end

endmodule

// File: rtl/button_event_scheduler.sv
// Shared debounce prescaler, NUM_BTN button channels and a round-robin
// arbiter feeding one registered valid/ready event port.
module button_event_scheduler
   import button_event_pkg::*;
#(
   parameter int NUM_BTN       = 5,
   parameter int TICK_DIV      = 250000,
   parameter int STABLE_TICKS  = 4,
   parameter int REPEAT_DELAY  = 200,
   parameter int REPEAT_PERIOD = 40,
   parameter int IDW           = $clog2(NUM_BTN)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic [NUM_BTN-1:0] repeat_en,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [IDW-1:0]     evt_btn,
   output logic [1:0]         evt_kind,
   output logic [NUM_BTN-1:0] btn_level,
   output logic               evt_drop,
   input  logic               clr_drop
);

   localparam int TW = $clog2(TICK_DIV);

   logic [TW-1:0]               tick_cnt;
   logic                        tick;
   slot_t [NUM_BTN-1:0]         slots;
   logic [NUM_BTN-1:0]          pend;
   logic [NUM_BTN-1:0]          drain;
   logic [NUM_BTN-1:0]          drop;
   logic [IDW-1:0]              rr_ptr;
   logic                        load;
   logic                        gnt_vld;
   logic [IDW-1:0]              gnt_idx;
   int                          sel;

   assign tick = (tick_cnt == TW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + TW'(1);
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      button_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .btn_raw  (btn_raw[i]),
         .tick     (tick),
         .drain    (drain[i]),
         .repeat_en(repeat_en[i]),
         .level    (btn_level[i]),
         .slot     (slots[i]),
         .drop     (drop[i])
      );
      assign pend[i] = slots[i].vld;
   end

   assign load = !evt_valid || evt_ready;

   // Search starts one past the last grant so every button gets a turn
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      sel     = 0;
      drain   = '0;
      for (int k = 1; k <= NUM_BTN; k++) begin
         sel = int'(rr_ptr) + k;
         if (sel >= NUM_BTN) sel = sel - NUM_BTN;
         if (!gnt_vld && pend[sel[IDW-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = sel[IDW-1:0];
         end
      end
      for (int i = 0; i < NUM_BTN; i++)
         drain[i] = load && gnt_vld && (gnt_idx == IDW'(i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_btn   <= '0;
         evt_kind  <= EVT_NONE;
         rr_ptr    <= '0;
      end else if (load) begin
         evt_valid <= gnt_vld;
         if (gnt_vld) begin
            evt_btn  <= gnt_idx;
            evt_kind <= slots[gnt_idx].kind;
            rr_ptr   <= gnt_idx;
         end else begin
            evt_btn  <= '0;
            evt_kind <= EVT_NONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        evt_drop <= 1'b0;
      else if (|drop)    evt_drop <= 1'b1;
      else if (clr_drop) evt_drop <= 1'b0;
   end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: directed scenarios plus random stimulus,
// checked every cycle against a run-length debounce model.
module tb_button_event_scheduler;

   localparam int NB = 4;
   localparam int TD = 4;
   localparam int ST = 3;
   localparam int RD = 5;
   localparam int RP = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] repeat_en;
   logic          evt_valid;
   logic          evt_ready;
   logic [1:0]    evt_btn;
   logic [1:0]    evt_kind;
   logic [NB-1:0] btn_level;
   logic          evt_drop;
   logic          clr_drop;

   int checks   = 0;
   int failures = 0;
   int cyc_no   = 0;

   typedef struct {
      int         t;
      logic [1:0] b;
      logic [1:0] k;
   } ev_t;
   ev_t evq[$];

   button_event_scheduler #(
      .NUM_BTN(NB), .TICK_DIV(TD), .STABLE_TICKS(ST),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .repeat_en(repeat_en),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_btn(evt_btn),
      .evt_kind(evt_kind), .btn_level(btn_level), .evt_drop(evt_drop),
      .clr_drop(clr_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_q(input int maxc, output int n);
      n = 0;
      while (evq.size() == 0 && n < maxc) begin cyc(1); n++; end
      check("evt_wait_timeout", int'(evq.size() > 0), 1);
   endtask

   task automatic pop(output ev_t e);
      if (evq.size() > 0) e = evq.pop_front();
      else begin e.t = -1; e.b = 2'd0; e.k = 2'd0; end
   endtask

   // Model: a level flips after ST consecutive tick samples that disagree with it
   bit         m_s1[NB], m_s2[NB], m_lvl[NB], m_pv[NB];
   int         m_run[NB], m_rpt[NB];
   bit [1:0]   m_pk[NB];
   bit         m_ov, m_drop;
   int         m_ob, m_rr, m_cnt;
   bit [1:0]   m_ok;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_cnt = 0; m_rr = 0; m_ov = 0; m_ob = 0; m_ok = 0; m_drop = 0;
         for (int i = 0; i < NB; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_pv[i] = 0;
            m_run[i] = 0; m_rpt[i] = 0; m_pk[i] = 0;
         end
      end else begin
         bit       tk, anyd, load;
         bit       post[NB];
         bit [1:0] pk[NB];
         int       g;
         tk = (m_cnt == TD - 1);
         for (int i = 0; i < NB; i++) begin
            post[i] = 0; pk[i] = 0;
            if (tk) begin
               if (m_s2[i] != m_lvl[i]) begin
                  m_run[i]++;
                  if (m_run[i] == ST) begin
                     m_lvl[i] = !m_lvl[i]; m_run[i] = 0; post[i] = 1;
                     pk[i] = m_lvl[i] ? 2'b01 : 2'b10;
                     if (m_lvl[i]) m_rpt[i] = 0;
                  end
               end else begin
                  if (m_lvl[i] && m_run[i] == 0) begin
                     if (repeat_en[i]) begin
                        m_rpt[i]++;
                        if (m_rpt[i] >= RD && (m_rpt[i] - RD) % RP == 0) begin
                           post[i] = 1; pk[i] = 2'b11;
                        end
                     end else m_rpt[i] = 0;
                  end
                  m_run[i] = 0;
               end
            end
         end
         load = !m_ov || evt_ready;
         g = -1;
         if (load)
            for (int k = 1; k <= NB; k++)
               if (g < 0 && m_pv[(m_rr + k) % NB]) g = (m_rr + k) % NB;
         if (load) begin
            if (g >= 0) begin m_ov = 1; m_ob = g; m_ok = m_pk[g]; m_rr = g; end
            else m_ov = 0;
         end
         anyd = 0;
         for (int i = 0; i < NB; i++) begin
            if (post[i]) begin
               if (m_pv[i] && g != i) anyd = 1;
               m_pv[i] = 1; m_pk[i] = pk[i];
            end else if (g == i) m_pv[i] = 0;
         end
         if (anyd) m_drop = 1;
         else if (clr_drop) m_drop = 0;
         for (int i = 0; i < NB; i++) begin m_s2[i] = m_s1[i]; m_s1[i] = btn_raw[i]; end
         m_cnt = (m_cnt + 1) % TD;
      end
   end

   initial forever begin
      logic [NB-1:0] lv;
      @(negedge clk);
      cyc_no++;
      for (int i = 0; i < NB; i++) lv[i] = m_lvl[i];
      check("evt_valid", int'(evt_valid), int'(m_ov));
      check("btn_level", int'(btn_level), int'(lv));
      check("evt_drop", int'(evt_drop), int'(m_drop));
      if (m_ov) begin
         check("evt_btn", int'(evt_btn), m_ob);
         check("evt_kind", int'(evt_kind), int'(m_ok));
      end
      if (evt_valid && evt_ready) evq.push_back('{cyc_no, evt_btn, evt_kind});
   end

   initial begin
      #800000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int  n, reps;
      ev_t e;
      rst_n = 0; btn_raw = '0; repeat_en = '0; evt_ready = 1; clr_drop = 0;
      cyc(3);
      check("rst_valid", int'(evt_valid), 0);
      check("rst_level", int'(btn_level), 0);
      check("rst_drop", int'(evt_drop), 0);
      check("rst_kind", int'(evt_kind), 0);
      rst_n = 1;
      cyc(2);

      // clean press / release of btn 2
      evq.delete();
      btn_raw[2] = 1;
      wait_q(40, n);
      check("t1_press_lat", int'(n >= 8 && n <= 22), 1);
      pop(e);
      check("t1_press_btn", int'(e.b), 2);
      check("t1_press_kind", int'(e.k), 1);
      check("t1_level_hi", int'(btn_level[2]), 1);
      cyc(160);
      check("t1_no_extra", evq.size(), 0);
      btn_raw[2] = 0;
      wait_q(40, n);
      check("t1_rel_lat", int'(n >= 8 && n <= 22), 1);
      pop(e);
      check("t1_rel_btn", int'(e.b), 2);
      check("t1_rel_kind", int'(e.k), 2);
      check("t1_level_lo", int'(btn_level[2]), 0);

      // one-tick bounce on btn 0, then steady
      evq.delete();
      for (int j = 0; j < 10; j++) begin btn_raw[0] = ~btn_raw[0]; cyc(TD); end
      cyc(8);
      check("t2_bounce_quiet", evq.size(), 0);
      btn_raw[0] = 1;
      wait_q(40, n);
      pop(e);
      check("t2_press_btn", int'(e.b), 0);
      check("t2_press_kind", int'(e.k), 1);
      btn_raw[0] = 0;
      cyc(40);
      pop(e);
      check("t2_rel_kind", int'(e.k), 2);

      // auto-repeat on btn 1, enabled then disabled
      for (int pass = 0; pass < 2; pass++) begin
         evq.delete();
         repeat_en[1] = (pass == 0);
         btn_raw[1] = 1;
         cyc(66);
         btn_raw[1] = 0;
         cyc(40);
         reps = 0;
         foreach (evq[j]) if (evq[j].k == 2'b11 && evq[j].b == 2'd1) reps++;
         check(pass == 0 ? "t3_repeats_en" : "t3_repeats_dis", reps, pass == 0 ? 5 : 0);
         check("t3_count", evq.size(), pass == 0 ? 7 : 2);
         pop(e);
         check("t3_first_press", int'(e.k), 1);
         if (evq.size() > 0) check("t3_last_release", int'(evq[evq.size()-1].k), 2);
         else check("t3_last_release", -1, 2);
      end
      repeat_en = '0;

      // simultaneous presses after reset: round-robin from index 1
      rst_n = 0; cyc(2); rst_n = 1;
      evq.delete();
      btn_raw = 4'b1011;
      cyc(30);
      check("t4_count", evq.size(), 3);
      if (evq.size() == 3) begin
         check("t4_g0", int'(evq[0].b), 1);
         check("t4_g1", int'(evq[1].b), 3);
         check("t4_g2", int'(evq[2].b), 0);
         check("t4_gap01", evq[1].t - evq[0].t, 1);
         check("t4_gap12", evq[2].t - evq[1].t, 1);
      end
      btn_raw = '0;
      cyc(30);

      // stalled consumer, slot overwrite and drop flag
      evq.delete();
      evt_ready = 0;
      btn_raw[0] = 1; cyc(24);
      btn_raw[0] = 0; cyc(24);
      check("t5_hold_valid", int'(evt_valid), 1);
      check("t5_hold_btn", int'(evt_btn), 0);
      check("t5_hold_kind", int'(evt_kind), 1);
      check("t5_no_drop", int'(evt_drop), 0);
      btn_raw[0] = 1; cyc(24);
      check("t5_drop_set", int'(evt_drop), 1);
      btn_raw[0] = 0; cyc(24);
      clr_drop = 1; cyc(1); clr_drop = 0;
      check("t5_drop_clr", int'(evt_drop), 0);
      evt_ready = 1;
      cyc(4);
      check("t5_drain_count", evq.size(), 2);
      pop(e); check("t5_drain0_kind", int'(e.k), 1);
      pop(e); check("t5_drain1_kind", int'(e.k), 2);

      // async reset while btn 3 held and event pending on the port
      btn_raw[3] = 1; evt_ready = 0;
      cyc(24);
      check("t6_pre_valid", int'(evt_valid), 1);
      check("t6_pre_btn", int'(evt_btn), 3);
      @(posedge clk); #3;
      rst_n = 0;
      #1;
      check("t6_async_valid", int'(evt_valid), 0);
      check("t6_async_btn", int'(evt_btn), 0);
      check("t6_async_kind", int'(evt_kind), 0);
      check("t6_async_level", int'(btn_level), 0);
      check("t6_async_drop", int'(evt_drop), 0);
      cyc(3);
      rst_n = 1; evt_ready = 1;
      evq.delete();
      wait_q(40, n);
      check("t6_repress_lat", int'(n >= 8 && n <= 22), 1);
      pop(e);
      check("t6_repress_btn", int'(e.b), 3);
      check("t6_repress_kind", int'(e.k), 1);
      btn_raw[3] = 0;
      cyc(30);

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NB; i++)
            if ($urandom_range(0, 39) == 0) btn_raw[i] = ~btn_raw[i];
         if ($urandom_range(0, 199) == 0) repeat_en = 4'($urandom_range(0, 15));
         evt_ready = ($urandom_range(0, 3) != 0);
         clr_drop  = ($urandom_range(0, 31) == 0);
         cyc(1);
      end
      btn_raw = '0; evt_ready = 1; clr_drop = 0;
      cyc(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
